// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: 0 TXDATA (push), 1 STATUS, 2 BAUDDIV, 3 CTRL. Reads are registered.
module io_uart_tx #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rstIO,
  input  logic [3:0]  addressIO,
  input  logic [31:0] dataInIO,
  input  logic        wEnIO,
  output logic [31:0] dataOutIO,
  output logic        txd
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q, state_d;
  logic [7:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    baud_q, baud_d;
  logic           en_q, en_d;
  logic [15:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic [31:0]    rdata_q, rdata_d;

  logic           full, empty, wr_txdata, push, pop, bit_end, busy;
  logic [15:0]    div_eff;
  logic [31:0]    count_w;
  logic [2:0]     cnt_sat;
  logic           unused_hi;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign wr_txdata = wEnIO && (addressIO == 4'h0);
  // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push      = wr_txdata && !full;
  assign pop       = (state_q == IDLE) && en_q && !empty;
  assign div_eff   = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign bit_end   = (bit_cnt_q == 16'd1);
  assign busy      = (state_q != IDLE);
  assign count_w   = 32'(count_q);
  assign cnt_sat   = (count_w > 32'd7) ? 3'd7 : count_w[2:0];
  assign unused_hi = ^dataInIO[31:16];

  // Control/status register updates from bus writes and dropped pushes.
  always_comb begin
    baud_d = baud_q;
    en_d   = en_q;
    ovf_d  = ovf_q;
    if (wEnIO) begin
      case (addressIO)
        4'h1: if (dataInIO[8]) ovf_d = 1'b0;
        4'h2: baud_d = dataInIO[15:0];
        4'h3: en_d = dataInIO[0];
        default: ;
      endcase
    end
    if (wr_txdata && full) ovf_d = 1'b1;
  end

  // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Transmit FSM; bit counter reloads from BAUDDIV at every bit boundary.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    if (state_q != IDLE) bit_cnt_d = bit_end ? div_eff : bit_cnt_q - 16'd1;
    case (state_q)
      IDLE: if (pop) begin
        state_d   = START;
        bit_cnt_d = div_eff;
        shift_d   = fifo_mem_q[rd_ptr_q];
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = 3'd0;
      end
      DATA: if (bit_end) begin
        shift_d = {1'b0, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // txd is registered from the current state, so the line lags the FSM by one cycle.
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  // Read mux, registered to match BRAM read latency.
  always_comb begin
    rdata_d = '0;
    case (addressIO)
      4'h1: rdata_d = {23'd0, ovf_q, 2'b00, cnt_sat, empty, full, busy};
      4'h2: rdata_d = {16'd0, baud_q};
      4'h3: rdata_d = {31'd0, en_q};
      default: rdata_d = '0;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy is reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= dataInIO[7:0];
  end

  // State registers; reset forces txd high immediately and empties the FIFO.
  always_ff @(posedge clk or negedge rstIO) begin
    if (!rstIO) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      baud_q    <= BAUD_DIV_RESET;
      en_q      <= 1'b1;
      bit_cnt_q <= 16'd1;
      idx_q     <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      baud_q    <= baud_d;
      en_q      <= en_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      rdata_q   <= rdata_d;
    end
  end

  assign dataOutIO = rdata_q;
  assign txd       = txd_q;
endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: bus-observing reference model feeds a frame scoreboard;
// a serial monitor decodes txd and checks each frame's start time and bit levels.
module tb_io_uart_tx;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstIO = 1'b0;
  logic [3:0]  addressIO = 4'h0;
  logic [31:0] dataInIO = 32'h0;
  logic        wEnIO = 1'b0;
  logic [31:0] dataOutIO;
  logic        txd;

  io_uart_tx #(.FIFO_DEPTH(DEPTH), .BAUD_DIV_RESET(16'd434)) dut (
    .clk(clk), .rstIO(rstIO), .addressIO(addressIO), .dataInIO(dataInIO),
    .wEnIO(wEnIO), .dataOutIO(dataOutIO), .txd(txd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] b; int start; } frame_t;
  frame_t     frame_q[$];
  int         dur_q[$];
  logic [7:0] m_fifo[$];
  int         m_div = 434;
  bit         m_en = 1'b1, m_ovf = 1'b0, m_busy = 1'b0;
  int         m_bit, m_bnd;
  int         pre_n, md, edge_n;
  frame_t     nf;

  // Each bit lasts max(BAUDDIV,1) as seen just before the edge that starts it.
  always @(posedge clk) begin
    if (!rstIO) begin
      m_fifo.delete(); frame_q.delete(); dur_q.delete();
      m_div = 434; m_en = 1'b1; m_ovf = 1'b0; m_busy = 1'b0;
    end else begin
      edge_n = cyc + 1;
      pre_n  = m_fifo.size();
      md     = (m_div == 0) ? 1 : m_div;
      if (m_busy) begin
        if (edge_n == m_bnd) begin
          m_bit++;
          if (m_bit == 10) m_busy = 1'b0;
          else begin dur_q.push_back(md); m_bnd = edge_n + md; end
        end
      end else if (m_en && pre_n > 0) begin
        nf.b = m_fifo.pop_front();
        nf.start = edge_n + 1;
        frame_q.push_back(nf);
        m_busy = 1'b1; m_bit = 0;
        dur_q.push_back(md); m_bnd = edge_n + md;
      end
      if (wEnIO) begin
        case (addressIO)
          4'h0: if (pre_n == DEPTH) m_ovf = 1'b1; else m_fifo.push_back(dataInIO[7:0]);
          4'h1: if (dataInIO[8]) m_ovf = 1'b0;
          4'h2: m_div = int'(dataInIO[15:0]);
          4'h3: m_en = dataInIO[0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] model_reg(input logic [3:0] a);
    int n = m_fifo.size();
    logic [2:0] c = (n > 7) ? 3'd7 : 3'(n);
    case (a)
      4'h1: return {23'd0, m_ovf, 2'b00, c, (n == 0), (n == DEPTH), m_busy};
      4'h2: return {16'd0, 16'(m_div)};
      4'h3: return {31'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_lvl(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // ---------------- serial monitor ----------------
  frame_t cur;
  int     mon_bit, mon_left;
  bit     mon_act = 1'b0, mon_ok, resync = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rstIO) begin
      mon_act = 1'b0; resync = 1'b0;
    end else if (resync) begin
      if (txd) resync = 1'b0;
    end else begin
      if (!mon_act && !txd) begin
        chk("frame_expected", 32'(frame_q.size() > 0 && dur_q.size() > 0), 1);
        if (frame_q.size() == 0 || dur_q.size() == 0) resync = 1'b1;
        else begin
          cur = frame_q.pop_front();
          chk($sformatf("frame_%02h_start", cur.b), cyc, cur.start);
          mon_act = 1'b1; mon_bit = 0; mon_ok = 1'b1;
          mon_left = dur_q.pop_front();
        end
      end
      if (mon_act) begin
        if (txd !== exp_lvl(cur.b, mon_bit)) mon_ok = 1'b0;
        mon_left--;
        if (mon_left == 0) begin
          chk($sformatf("frame_%02h_bit%0d_level", cur.b, mon_bit), mon_ok, 1);
          mon_bit++;
          if (mon_bit == 10) mon_act = 1'b0;
          else if (dur_q.size() == 0) begin
            chk("bit_duration_known", 32'(dur_q.size()), 1);
            mon_act = 1'b0; resync = 1'b1;
          end else begin
            mon_left = dur_q.pop_front(); mon_ok = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    addressIO = a; dataInIO = d; wEnIO = 1'b1;
    @(posedge clk); #1;
    wEnIO = 1'b0; dataInIO = $urandom;
  endtask

  task automatic rd(input logic [3:0] a, input string name);
    logic [31:0] e;
    @(negedge clk); #1;
    addressIO = a; e = model_reg(a);
    @(posedge clk); #1;
    chk(name, dataOutIO, e);
  endtask

  task automatic rdc(input logic [3:0] a, input logic [31:0] e, input string name);
    @(negedge clk); #1;
    addressIO = a;
    @(posedge clk); #1;
    chk(name, dataOutIO, e);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_busy || (m_en && m_fifo.size() > 0) || mon_act || frame_q.size() > 0) && k < budget) begin
      @(negedge clk); k++;
    end
    chk("idle_within_budget", 32'(k < budget), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1 rstIO = 1'b1;
    chk("reset_txd", txd, 1);
    rdc(4'h0, 32'h0,   "reset_txdata");
    rdc(4'h1, 32'h004, "reset_status");
    rdc(4'h2, 32'd434, "reset_bauddiv");
    rdc(4'h3, 32'h1,   "reset_ctrl");
    rdc(4'h4, 32'h0,   "reset_addr4");

    // single frame, div 4
    wr(4'h2, 32'd4);
    wr(4'h0, 32'hA5);
    wait_idle(200);
    rdc(4'h1, 32'h004, "a5_status_after");

    // overflow with transmitter disabled
    wr(4'h2, 32'd2);
    wr(4'h3, 32'd0);
    for (int i = 0; i < 5; i++) wr(4'h0, $urandom);
    rdc(4'h1, 32'h122, "ovf_status");
    wr(4'h1, 32'h100);
    rdc(4'h1, 32'h022, "ovf_cleared");
    wr(4'h3, 32'd1);
    wait_idle(300);
    rdc(4'h1, 32'h004, "drain_status");

    // BAUDDIV change during the second data bit
    wr(4'h2, 32'd8);
    wr(4'h0, 32'(($urandom_range(0, 255))));
    repeat (17) @(posedge clk);
    wr(4'h2, 32'd3);
    wait_idle(300);
    rd(4'h2, "bauddiv_readback");

    // BAUDDIV 0 behaves as 1
    wr(4'h2, 32'd0);
    wr(4'h0, 32'h00);
    wait_idle(100);
    rd(4'h1, "div0_status");

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: wr(4'h0, $urandom);
        4: wr(4'h2, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3)));
        5: wr(4'h3, 32'($urandom_range(0, 1)));
        6: wr(4'h1, $urandom);
        7: wr(4'(4 + $urandom_range(0, 11)), $urandom);
        8: rd(4'($urandom_range(0, 15)), "rand_read");
        default: repeat ($urandom_range(1, 20)) @(posedge clk);
      endcase
    end
    wr(4'h3, 32'd1);
    wait_idle(5000);
    for (int a = 0; a < 16; a++) rd(4'(a), "final_regs");

    // reset in the middle of a frame with two bytes queued
    wr(4'h2, 32'd4);
    wr(4'h0, 32'h00);
    wr(4'h0, $urandom);
    wr(4'h0, $urandom);
    repeat (12) @(posedge clk);
    #2 chk("pre_reset_txd_low", txd, 0);
    rstIO = 1'b0;
    #1 chk("reset_txd_async", txd, 1);
    repeat (2) @(posedge clk);
    #1 rstIO = 1'b1;
    rdc(4'h1, 32'h004, "post_reset_status");
    rdc(4'h2, 32'd434, "post_reset_bauddiv");
    repeat (150) @(posedge clk);
    chk("post_reset_txd_idle", txd, 1);
    chk("scoreboard_empty", 32'(frame_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter peripheral sitting on the IO side of the memory controller. It responds to the controller's 4-bit IO address, 32-bit write data and write-enable, and returns registered read data with the same one-cycle latency as the BRAM. Bytes the CPU writes to it are queued in a small FIFO and serialised 8N1 on `txd`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of 2, minimum 2.
- `BAUD_DIV_RESET`, 16'd434: reset value of BAUDDIV, in clock cycles per bit.

Ports:
- `clk`  input  1  system clock. All logic is rising-edge.
- `rstIO`  input  1  reset, asynchronous and active-low.
- `addressIO`  input  4  IO register address.
- `dataInIO`  input  32  write data.
- `wEnIO`  input  1  write strobe, one cycle per write.
- `dataOutIO`  output  32  registered read data for the address of the previous cycle.
- `txd`  output  1  serial output; idles high.

## Operation
Register map (word index on `addressIO`):
- 0x0 TXDATA
  - Write pushes `dataInIO[7:0]`.
  - Reads 0.
- 0x1 STATUS, read-only except bit 8:
  - bit 0: busy (FSM not IDLE).
  - bit 1: fifo_full.
  - bit 2: fifo_empty.
  - bits [5:3]: fifo count, saturating at 7.
  - bit 8: overflow, sticky. Writing with `dataInIO[8]`=1 clears it.
  - All other bits read 0.
- 0x2 BAUDDIV: R/W, bits [15:0]. A value of 0 is treated as 1. Upper bits read 0.
- 0x3 CTRL: R/W, bit 0 = enable, reset 1. Other bits read 0.
- 0x4–0xF: read 0; writes ignored.

FIFO behaviour:
- A push when the count at the start of the cycle equals `FIFO_DEPTH` is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.

Transmit FSM (IDLE, START, DATA, STOP):
- IDLE → START: when enable=1 and the FIFO is non-empty. The head entry is popped into the shift register on that edge.
- START: `txd`=0 for one bit period.
- DATA: 8 bits, LSB first, one bit period each. A 3-bit index counts 0..7.
- STOP: `txd`=1 for one bit period, then → IDLE.
- One bit period = max(BAUDDIV,1) cycles. The bit counter reloads from BAUDDIV at the start of each bit, so a BAUDDIV write mid-frame takes effect at the next bit boundary.
- Clearing enable mid-frame: the current frame completes, and no new pop occurs.
- Reset mid-frame: `txd` returns high immediately, the FIFO is emptied, and the byte in flight is lost.

## Timing
Reset values:
- `txd`=1, `dataOutIO`=0.
- FSM in IDLE.
- FIFO empty, overflow=0.
- BAUDDIV=`BAUD_DIV_RESET`, enable=1.

Read and write timing:
- Read latency is 1 cycle: `dataOutIO` at edge N+1 reflects the register state after edge N for `addressIO` sampled at edge N. This matches BRAM latency so the controller mux needs no extra alignment.
- Writes take effect at the edge where `wEnIO`=1. A STATUS read in the following cycle sees the new count.

Frame timing:
- With an idle FSM and enable=1, a TXDATA write at edge W causes:
  - pop at edge W+1;
  - `txd` falling at edge W+2;
  - frame length exactly 10×div cycles.
- Back-to-back frames: one IDLE cycle between the end of STOP and the next START (frame pitch 10×div+1).
- busy is 1 from the pop edge through the last STOP cycle.

## Test plan
- Reset, then read all addresses 0x0–0x4:
  - STATUS=0x004, BAUDDIV=434, CTRL=1, others 0.
  - `txd`=1.
- BAUDDIV=4, write 0xA5 to TXDATA:
  - `txd` low 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles.
  - Falling edge at W+2.
  - busy drops after 40 cycles.
- BAUDDIV=2, enable=0, write 5 bytes:
  - 4 are queued; the 5th is dropped.
  - STATUS = full|count=4|overflow = 0x122.
  - Writing 0x100 to STATUS clears overflow.
  - Set enable=1: 4 frames with 21-cycle pitch, then STATUS=0x004.
- BAUDDIV=8, start a frame, write BAUDDIV=3 during the 2nd data bit:
  - That bit lasts 8 cycles.
  - Following bits last 3 cycles.
- BAUDDIV=0, write 0x00:
  - Every bit lasts 1 cycle.
  - `txd` low 9 consecutive cycles (start plus 8 zero data bits), then high.
- Assert `rstIO` mid-DATA with 2 bytes queued:
  - `txd`=1 immediately, asynchronously.
  - After release: STATUS=0x004, and no further frames.
